sync_frame_sequencer: RTL
=========================

Name: sync_frame_sequencer

Overview:
- Frame-level controller downstream of the synchronization stage.
- Consumes the synchronized baseband stream: sample, frequency-offset estimate, and a detection-end flag on the last-beat signal.
- Sequences each burst: search for detection, latch CFO, discard alignment samples, gate a programmed number of samples to the demodulator, then hold off before re-arming.
- Drops everything outside a frame, so downstream blocks only see aligned bursts.

Parameters:
- WIDTH, 32, sample width (packed {Q,I}).
- OFFSET, 8, samples discarded after detection end before capture starts (0 = none).
- HOLDOFF, 16, samples discarded after a frame before re-arming (0 = none).
- COUNT_WIDTH, 16, width of the frame_len port and internal counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  arm sequencer; level-sensitive
- abort  in  1  synchronous abort pulse; returns to IDLE
- frame_len  in  COUNT_WIDTH  samples per frame; sampled on detection
- s_valid  in  1  input stream valid
- s_ready  out  1  input stream ready
- s_data  in  WIDTH  input sample
- s_user  in  32  frequency-offset estimate
- s_last  in  1  detection-end flag
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- m_data  out  WIDTH  captured sample
- m_last  out  1  final sample of frame
- cfo  out  32  latched frequency offset
- cfo_valid  out  1  one-cycle pulse when cfo updates
- state  out  3  IDLE=0, SEARCH=1, ALIGN=2, CAPTURE=3, HOLDOFF=4
- frames  out  COUNT_WIDTH  completed-frame count (stats)
- overruns  out  COUNT_WIDTH  s_last seen outside SEARCH (stats)

Behaviour:
Reset and acceptance:
- Reset values: state=IDLE; m_valid=0, m_last=0, m_data=0; cfo=0, cfo_valid=0; counters=0; frames=0, overruns=0.
- A beat is accepted when s_valid && s_ready.
- s_ready=1 in IDLE, SEARCH, ALIGN and HOLDOFF; beats are accepted and dropped, so upstream never stalls outside a frame.
- In CAPTURE, s_ready = !m_valid || m_ready (single registered output stage).
- Latency input->output is 1 cycle. Throughput is 1 beat/cycle with m_ready held high.
- m_valid/m_data/m_last hold stable while m_valid && !m_ready.

State machine (transitions on accepted beats unless noted):
- IDLE: enable=1 -> SEARCH next cycle.
- SEARCH: enable=0 -> IDLE. Accepted beat with s_last=1:
  - cfo<=s_user; cfo_valid pulses 1 cycle; len<=frame_len.
  - Next state is ALIGN (cnt<=OFFSET-1) if OFFSET>0, else CAPTURE.
  - If frame_len==0: go to HOLDOFF (or SEARCH if HOLDOFF==0), no output, frames unchanged.
  - The detection beat itself is never forwarded.
- ALIGN: each accepted beat is dropped; at cnt==0 -> CAPTURE (cnt<=len-1), else cnt decrements.
- CAPTURE:
  - Each accepted beat is loaded into the output register.
  - m_last=1 when cnt==0; frames increments (wraps) on that accept.
  - Then HOLDOFF (cnt<=HOLDOFF-1) if HOLDOFF>0, else SEARCH.
- HOLDOFF: drop beats; at cnt==0 -> SEARCH if enable else IDLE.

Boundary conditions:
- s_last=1 accepted in ALIGN/CAPTURE/HOLDOFF: ignored for sequencing; overruns increments (saturating).
- enable deasserted during ALIGN/CAPTURE/HOLDOFF: the frame completes, then IDLE.
- abort (any state, priority over everything): next cycle state=IDLE, m_valid=0, m_last=0, counters cleared.
  - A pending output beat is discarded.
  - cfo and the stats counters are retained.
- abort and an accept in the same cycle: the beat is consumed and dropped.
- frame_len changes mid-frame: no effect until the next detection.
- Counters: unsigned COUNT_WIDTH. The frame counter wraps modulo 2^COUNT_WIDTH; the overrun counter saturates at all-ones.
- Asynchronous reset mid-frame: immediate return to reset values, including the stats counters.

Optional Feature:
- Macro: SYNC_FRAME_SEQUENCER_STATS_EN.
- Defined: frames and overruns count as specified.
- Undefined: both ports are tied to 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Nominal frame: reset, enable=1, frame_len=160, OFFSET=8, HOLDOFF=16; stream ramp 0..399 with s_last on sample 50, s_user=0x0000_0123.
  -> cfo=0x123 with one cfo_valid pulse; m_data=59..218 (160 beats); m_last only on 218; frames=1; state returns to SEARCH after sample 234.
- Backpressure: same stimulus, m_ready random 50%.
  -> identical output sequence; no beat lost or duplicated; m_data stable while stalled; s_ready low only in CAPTURE while m_valid && !m_ready.
- Overrun: second s_last at sample 100, inside CAPTURE.
  -> frame unaffected (still ends on 218); overruns=1; cfo unchanged.
- Abort mid-capture: abort pulse at the 40th captured beat with m_ready=0.
  -> next cycle m_valid=0, state=IDLE; held beat dropped; frames=0; cfo retained.
- Zero length and disable: frame_len=0 detection -> no m_valid, state passes HOLDOFF to SEARCH. enable=0 during CAPTURE -> frame finishes with m_last, then state=IDLE.
- Macro off: rerun the nominal case without SYNC_FRAME_SEQUENCER_STATS_EN.
  -> identical stream output; frames=overruns=0.

Source files
------------

// File: rtl/sync_frame_sequencer.sv
// Burst sequencer after the sync stage: detect, latch CFO, skip alignment samples,
// gate frame_len samples to the demodulator, then hold off. Stats: SYNC_FRAME_SEQUENCER_STATS_EN.
module sync_frame_sequencer #(
    parameter int WIDTH       = 32,
    parameter int OFFSET      = 8,
    parameter int HOLDOFF     = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] frame_len,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    input  logic [31:0]            s_user,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_last,
    output logic [31:0]            cfo,
    output logic                   cfo_valid,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] frames,
    output logic [COUNT_WIDTH-1:0] overruns
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEARCH  = 3'd1;
    localparam logic [2:0] ST_ALIGN   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] OFFSET_LAST = COUNT_WIDTH'((OFFSET > 0) ? OFFSET - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST   = COUNT_WIDTH'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [2:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [WIDTH-1:0]       m_data_q, m_data_d;
    logic [31:0]            cfo_q, cfo_d;
    logic                   cfo_valid_q, cfo_valid_d;
    logic                   accept;
    logic                   cnt_zero;
    logic [2:0]             rearm_state;

    // Outside CAPTURE the stream is always drained so upstream never stalls.
    assign s_ready     = (state_q == ST_CAPTURE) ? (!m_valid_q || m_ready) : 1'b1;
    assign accept      = s_valid && s_ready;
    assign cnt_zero    = (cnt_q == '0);
    assign rearm_state = enable ? ST_SEARCH : ST_IDLE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        cfo_d       = cfo_q;
        cfo_valid_d = 1'b0;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            len_d     = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (accept && s_last) begin
                        cfo_d       = s_user;
                        cfo_valid_d = 1'b1;
                        len_d       = frame_len;
                        if (frame_len == '0) begin
                            state_d = (HOLDOFF > 0) ? ST_HOLDOFF : ST_SEARCH;
                            cnt_d   = HOLD_LAST;
                        end else if (OFFSET > 0) begin
                            state_d = ST_ALIGN;
                            cnt_d   = OFFSET_LAST;
                        end else begin
                            state_d = ST_CAPTURE;
                            cnt_d   = frame_len - ONE;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (accept) begin
                        if (cnt_zero) begin
                            state_d = ST_CAPTURE;
                            cnt_d   = len_q - ONE;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        m_valid_d = 1'b1;
                        m_data_d  = s_data;
                        m_last_d  = cnt_zero;
                        if (cnt_zero) begin
                            state_d = (HOLDOFF > 0) ? ST_HOLDOFF : rearm_state;
                            cnt_d   = HOLD_LAST;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (accept) begin
                        if (cnt_zero) state_d = rearm_state;
                        else          cnt_d   = cnt_q - ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            cfo_q       <= '0;
            cfo_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            cfo_q       <= cfo_d;
            cfo_valid_q <= cfo_valid_d;
        end
    end

    assign state     = state_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_data    = m_data_q;
    assign cfo       = cfo_q;
    assign cfo_valid = cfo_valid_q;

`ifdef SYNC_FRAME_SEQUENCER_STATS_EN
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;
    logic [COUNT_WIDTH-1:0] overruns_q, overruns_d;

    // Frame count wraps; overrun count saturates at all-ones.
    always_comb begin
        frames_d   = frames_q;
        overruns_d = overruns_q;
        if (!abort && accept) begin
            if (state_q == ST_CAPTURE && cnt_zero) frames_d = frames_q + ONE;
            if (s_last && overruns_q != '1 &&
                (state_q == ST_ALIGN || state_q == ST_CAPTURE || state_q == ST_HOLDOFF))
                overruns_d = overruns_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_q   <= '0;
            overruns_q <= '0;
        end else begin
            frames_q   <= frames_d;
            overruns_q <= overruns_d;
        end
    end

    assign frames   = frames_q;
    assign overruns = overruns_q;
`else
    assign frames   = '0;
    assign overruns = '0;
`endif
endmodule
